// File: rtl/quarter_sine_interp.sv
// rtl/quarter_sine_interp.sv - quarter-wave folded sine generator with optional linear interpolation
//
// Optional feature macro: QSINE_INTERP_EN
//   defined     : second ROM read port, interpolation stage, latency 4
//   not defined : table lookup only, sub-index bits ignored, latency 3
//
// Ports:
//   clk        single clock, rising edge
//   reset_n    asynchronous active-low reset
//   in_valid   phase sample present this cycle
//   in_phase   unsigned phase word, full turn = 2^PHASE_W
//   in_cos     1 = add a quarter turn (cosine)
//   in_ch      channel tag, carried alongside the sample
//   out_valid  out_val/out_ch carry a new sample this cycle
//   out_val    signed two's-complement sine sample (holds while out_valid=0)
//   out_ch     tag of the sample on out_val (holds while out_valid=0)

module quarter_sine_interp #(
    parameter int PHASE_W = 16,
    parameter int OUT_W   = 16,
    parameter int LUT_AW  = 8,
    parameter int CH_W    = 3
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    input  logic [PHASE_W-1:0]      in_phase,
    input  logic                    in_cos,
    input  logic [CH_W-1:0]         in_ch,
    output logic                    out_valid,
    output logic signed [OUT_W-1:0] out_val,
    output logic [CH_W-1:0]         out_ch
);

    localparam int FRAC_W = PHASE_W - 2 - LUT_AW;
    localparam int DEPTH  = 1 << LUT_AW;

    // Table entry k samples the quarter wave at the centre of its bin,
    // (k+0.5)/DEPTH, so that indexing with ~q lands on the mirror bin exactly.
    // Sine is evaluated with a Taylor series so only basic real arithmetic is
    // needed at elaboration.
    function automatic logic signed [OUT_W-1:0] rom_entry(input int k);
        real x;
        real term;
        real s;
        x    = 3.14159265358979323846 / 2.0 * ($itor(k) + 0.5) / $itor(DEPTH);
        term = x;
        s    = x;
        for (int n = 1; n < 12; n++) begin
            term = -term * x * x / $itor((2 * n) * (2 * n + 1));
            s    = s + term;
        end
        return OUT_W'($rtoi(s * ($itor(2 ** (OUT_W - 1)) - 1.0) + 0.5));
    endfunction

    logic signed [OUT_W-1:0] rom [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        assign rom[i] = rom_entry(i);
    end

    // ---------------------------------------------------------------
    // S1: quarter-turn offset and fold. Adding 2^(PHASE_W-2) only touches
    // the two quadrant bits, so the offset is a 2-bit add.
    // ---------------------------------------------------------------
    logic [1:0]         quad;
    logic [PHASE_W-3:0] q_fold;

    assign quad   = in_phase[PHASE_W-1:PHASE_W-2] + {1'b0, in_cos};
    assign q_fold = quad[0] ? ~in_phase[PHASE_W-3:0] : in_phase[PHASE_W-3:0];

    logic              s1_valid;
    logic              s1_neg;
    logic [LUT_AW-1:0] s1_k;
    logic [CH_W-1:0]   s1_ch;
`ifdef QSINE_INTERP_EN
    logic [FRAC_W-1:0] s1_f;
`else
    logic unused_frac;
    assign unused_frac = ^q_fold[FRAC_W-1:0];
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_neg   <= 1'b0;
            s1_k     <= '0;
            s1_ch    <= '0;
`ifdef QSINE_INTERP_EN
            s1_f     <= '0;
`endif
        end else begin
            s1_valid <= in_valid;
            s1_neg   <= quad[1];
            s1_k     <= q_fold[PHASE_W-3 -: LUT_AW];
            s1_ch    <= in_ch;
`ifdef QSINE_INTERP_EN
            s1_f     <= q_fold[FRAC_W-1:0];
`endif
        end
    end

    // ---------------------------------------------------------------
    // S2: registered ROM read
    // ---------------------------------------------------------------
    logic                    s2_valid;
    logic                    s2_neg;
    logic [CH_W-1:0]         s2_ch;
    logic signed [OUT_W-1:0] s2_a;
`ifdef QSINE_INTERP_EN
    logic signed [OUT_W-1:0] s2_b;
    logic [FRAC_W-1:0]       s2_f;
    logic [LUT_AW-1:0]       k_next;

    // The last bin has no upper neighbour inside the quarter; hold flat
    // rather than wrapping to the bottom of the table.
    assign k_next = (s1_k == {LUT_AW{1'b1}}) ? s1_k : s1_k + 1'b1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid <= 1'b0;
            s2_neg   <= 1'b0;
            s2_ch    <= '0;
            s2_a     <= '0;
`ifdef QSINE_INTERP_EN
            s2_b     <= '0;
            s2_f     <= '0;
`endif
        end else begin
            s2_valid <= s1_valid;
            s2_neg   <= s1_neg;
            s2_ch    <= s1_ch;
            s2_a     <= rom[s1_k];
`ifdef QSINE_INTERP_EN
            s2_b     <= rom[k_next];
            s2_f     <= s1_f;
`endif
        end
    end

    // Signals feeding the output stage, sourced from S3 or S2 by build.
    logic                    pre_valid;
    logic                    pre_neg;
    logic [CH_W-1:0]         pre_ch;
    logic signed [OUT_W-1:0] pre_y;

`ifdef QSINE_INTERP_EN
    // ---------------------------------------------------------------
    // S3: linear interpolation, y = a + ((b-a)*f >>> FRAC_W)
    // ---------------------------------------------------------------
    localparam int PROD_W = OUT_W + FRAC_W + 2;

    logic signed [OUT_W:0]    diff;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] shifted;
    logic signed [OUT_W-1:0]  y_interp;

    assign diff     = $signed({s2_b[OUT_W-1], s2_b}) - $signed({s2_a[OUT_W-1], s2_a});
    assign prod     = diff * $signed({1'b0, s2_f});
    assign shifted  = prod >>> FRAC_W;
    assign y_interp = OUT_W'(shifted + PROD_W'(s2_a));

    logic                    s3_valid;
    logic                    s3_neg;
    logic [CH_W-1:0]         s3_ch;
    logic signed [OUT_W-1:0] s3_y;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s3_valid <= 1'b0;
            s3_neg   <= 1'b0;
            s3_ch    <= '0;
            s3_y     <= '0;
        end else begin
            s3_valid <= s2_valid;
            s3_neg   <= s2_neg;
            s3_ch    <= s2_ch;
            s3_y     <= y_interp;
        end
    end

    assign pre_valid = s3_valid;
    assign pre_neg   = s3_neg;
    assign pre_ch    = s3_ch;
    assign pre_y     = s3_y;
`else
    assign pre_valid = s2_valid;
    assign pre_neg   = s2_neg;
    assign pre_ch    = s2_ch;
    assign pre_y     = s2_a;
`endif

    // ---------------------------------------------------------------
    // S4: sign restore and output register. |y| never reaches the most
    // negative code, so negation cannot overflow.
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_val   <= '0;
            out_ch    <= '0;
        end else begin
            out_valid <= pre_valid;
            if (pre_valid) begin
                out_val <= pre_neg ? -pre_y : pre_y;
                out_ch  <= pre_ch;
            end
        end
    end

endmodule

// File: tb/tb_quarter_sine_interp.sv
// tb/tb_quarter_sine_interp.sv - scoreboard bench for quarter_sine_interp
`timescale 1ns/1ps

module tb_quarter_sine_interp;

`ifdef QSINE_INTERP_EN
    localparam int LAT = 4;
    localparam logic signed [15:0] EXP_3F = 16'sd298;
`else
    localparam int LAT = 3;
    localparam logic signed [15:0] EXP_3F = 16'sd101;
`endif
    localparam real PI = 3.14159265358979323846;

    logic               clk;
    logic               reset_n;
    logic               in_valid;
    logic [15:0]        in_phase;
    logic               in_cos;
    logic [2:0]         in_ch;
    logic               out_valid;
    logic signed [15:0] out_val;
    logic [2:0]         out_ch;

    quarter_sine_interp dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_phase  (in_phase),
        .in_cos    (in_cos),
        .in_ch     (in_ch),
        .out_valid (out_valid),
        .out_val   (out_val),
        .out_ch    (out_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic signed [15:0] val;
        logic [2:0]         ch;
        int                 cyc;
    } exp_t;

    exp_t sb[$];
    int   seen[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle_cnt = 0;
    bit   capture_en = 1'b0;
    logic signed [15:0] last_val;
    logic [2:0]         last_ch;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    function automatic int ref_l(input int k);
        return $rtoi(32767.0 * $sin(PI / 2.0 * ($itor(k) + 0.5) / 256.0) + 0.5);
    endfunction

    function automatic logic signed [15:0] model(input logic [15:0] ph, input bit cs);
        logic [15:0] p;
        logic [13:0] q;
        int k, f, a, b, y;
        p = ph + (cs ? 16'h4000 : 16'h0000);
        q = p[14] ? ~p[13:0] : p[13:0];
        k = int'(q[13:6]);
        f = int'(q[5:0]);
        a = ref_l(k);
        b = (k == 255) ? a : ref_l(k + 1);
`ifdef QSINE_INTERP_EN
        y = a + (((b - a) * f) >>> 6);
`else
        y = a + 0 * (b + f);
`endif
        return p[15] ? 16'(-y) : 16'(y);
    endfunction

    // Output monitor: pops the scoreboard, checks value, tag and exact latency,
    // and checks that outputs hold during bubbles.
    always @(negedge clk) begin
        if (!reset_n) begin
            last_val = '0;
            last_ch  = '0;
        end else if (out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: out_valid=1 val=%0d, required no output", out_val);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checks++;
                if (out_val !== e.val) begin
                    errors++;
                    $display("FAIL out_val: got %0d, required %0d", out_val, e.val);
                end
                checks++;
                if (out_ch !== e.ch) begin
                    errors++;
                    $display("FAIL out_ch: got %0d, required %0d", out_ch, e.ch);
                end
                checks++;
                if (cycle_cnt - e.cyc !== LAT) begin
                    errors++;
                    $display("FAIL latency: got %0d, required %0d", cycle_cnt - e.cyc, LAT);
                end
            end
            last_val = out_val;
            last_ch  = out_ch;
            if (capture_en) seen.push_back(int'(out_val));
        end else begin
            checks++;
            if (out_val !== last_val || out_ch !== last_ch) begin
                errors++;
                $display("FAIL hold: got val=%0d ch=%0d, required val=%0d ch=%0d",
                         out_val, out_ch, last_val, last_ch);
            end
        end
    end

    task automatic step(input bit v, input logic [15:0] ph, input bit cs, input logic [2:0] ch,
                        input bit use_model, input logic signed [15:0] exp_val);
        exp_t e;
        in_valid = v;
        in_phase = ph;
        in_cos   = cs;
        in_ch    = ch;
        if (v) begin
            e.val = use_model ? model(ph, cs) : exp_val;
            e.ch  = ch;
            e.cyc = cycle_cnt;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain;
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d entries left, required 0", sb.size());
            sb.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_phase = '0;
        in_cos   = 1'b0;
        in_ch    = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_val !== 16'sd0 || out_ch !== 3'd0) begin
            errors++;
            $display("FAIL reset_state: got valid=%0b val=%0d ch=%0d, required 0 0 0",
                     out_valid, out_val, out_ch);
        end
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_corners;
        step(1'b1, 16'h0000, 1'b0, 3'd1, 1'b0, 16'sd101);
        step(1'b1, 16'h8000, 1'b0, 3'd2, 1'b0, -16'sd101);
        step(1'b1, 16'h4000, 1'b0, 3'd3, 1'b0, 16'sd32767);
        step(1'b1, 16'hC000, 1'b0, 3'd4, 1'b0, -16'sd32767);
        step(1'b1, 16'h0000, 1'b1, 3'd5, 1'b0, 16'sd32767);
        step(1'b1, 16'h003F, 1'b0, 3'd6, 1'b0, EXP_3F);
        step(1'b1, 16'h7FFF, 1'b1, 3'd7, 1'b1, 16'sd0);
        step(1'b1, 16'hFFFF, 1'b0, 3'd0, 1'b1, 16'sd0);
        wait_drain();
    endtask

    task automatic test_sweep;
        seen.delete();
        capture_en = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            logic [15:0] ph;
            ph = 16'(i);
            step(1'b1, ph, 1'b0, ph[2:0], 1'b1, 16'sd0);
        end
        wait_drain();
        capture_en = 1'b0;
        checks++;
        if (seen.size() != 65536) begin
            errors++;
            $display("FAIL sweep_count: got %0d, required 65536", seen.size());
        end else begin
            for (int i = 0; i < 32768; i++) begin
                checks++;
                if (seen[i] != -seen[i + 32768]) begin
                    errors++;
                    $display("FAIL symmetry p=%0h: got %0d, required %0d", i, seen[i], -seen[i + 32768]);
                end
            end
`ifdef QSINE_INTERP_EN
            for (int i = 0; i < 65536; i++) begin
                real pos, ideal, err;
                logic [15:0] p;
                p     = 16'(i);
                pos   = p[14] ? $itor(i - 31) : $itor(i + 32);
                ideal = 32767.0 * $sin(2.0 * PI * pos / 65536.0);
                err   = $itor(seen[i]) - ideal;
                checks++;
                if (err > 2.0 || err < -2.0) begin
                    errors++;
                    $display("FAIL accuracy p=%0h: got %0d, required %f +/-2", i, seen[i], ideal);
                end
            end
`endif
        end
    endtask

    task automatic test_back_to_back;
        logic [2:0] tag;
        tag = 3'd0;
        for (int i = 0; i < 20; i++) begin
            bit v;
            v = (i % 5 != 1) && (i % 5 != 4);
            step(v, 16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)), tag, 1'b1, 16'sd0);
            if (v) tag = tag + 3'd1;
        end
        wait_drain();
    endtask

    task automatic test_reset_midstream;
        step(1'b1, 16'h1000, 1'b0, 3'd1, 1'b1, 16'sd0);
        step(1'b1, 16'h2000, 1'b0, 3'd2, 1'b1, 16'sd0);
        step(1'b1, 16'h3000, 1'b0, 3'd3, 1'b1, 16'sd0);
        reset_n = 1'b0;
        sb.delete();
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_val !== 16'sd0 || out_ch !== 3'd0) begin
            errors++;
            $display("FAIL midreset_async: got valid=%0b val=%0d ch=%0d, required 0 0 0",
                     out_valid, out_val, out_ch);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (out_valid !== 1'b0 || out_val !== 16'sd0) begin
                errors++;
                $display("FAIL midreset_flush cycle %0d: got valid=%0b val=%0d, required 0 0",
                         i, out_valid, out_val);
            end
            @(posedge clk);
            #1;
        end
        step(1'b1, 16'h4000, 1'b0, 3'd5, 1'b0, 16'sd32767);
        wait_drain();
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_corners();
        test_back_to_back();
        test_reset_midstream();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/quarter_sine_interp.md
# quarter_sine_interp

Parametrised quarter-wave sine generator, successor to the fixed 16-bit quarter-wave sine block. Accepts one phase word per cycle and folds it onto a single quarter-wave ROM using sign and mirror bits. Optionally refines the ROM output by linear interpolation on the sub-index phase bits. Sits between the per-voice phase accumulators and the voice mixer, carrying a channel tag so time-multiplexed voices stay aligned through the fixed-latency pipeline.

## Interface
- PHASE_W, 16, phase word width (≥ LUT_AW+3)
- OUT_W, 16, signed output width
- LUT_AW, 8, log2 of quarter-wave ROM entries
- CH_W, 3, channel tag width
- clk  in  1  single clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  phase sample present this cycle
- in_phase  in  PHASE_W  unsigned phase, full turn = 2^PHASE_W
- in_cos  in  1  1 = output cosine (phase + quarter turn)
- in_ch  in  CH_W  channel tag, passed through
- out_valid  out  1  out_val/out_ch valid this cycle
- out_val  out  OUT_W  signed two's-complement sine sample
- out_ch  out  CH_W  tag of the sample on out_val

## Operation
- FRAC_W = PHASE_W-2-LUT_AW.
- Effective phase p = in_phase + (in_cos ? 2^(PHASE_W-2) : 0), modulo 2^PHASE_W (wraps silently).
- p[PHASE_W-1] = negate, p[PHASE_W-2] = mirror, low PHASE_W-2 bits = q.
- Mirror=1: q replaced by bitwise ~q. Index k = q[MSBs of LUT_AW]; frac f = q[FRAC_W-1:0].
- ROM entry L[k] = round((2^(OUT_W-1)-1)·sin(π/2·(k+0.5)/2^LUT_AW)); half-step offset makes ~q mirror exact. ROM is synchronous (registered read), contents generated at elaboration, no init file.
- Interpolation (macro on): y = L[k] + (((L[k+1]-L[k])·f) >>> FRAC_W).
  - Difference signed, OUT_W+1 bits; product OUT_W+1+FRAC_W bits; arithmetic shift truncates toward −∞.
  - At k = 2^LUT_AW−1, L[k+1] is taken as L[k] (flat top, no wrap into L[0]).
- Output = negate ? −y : y. |y| ≤ 2^(OUT_W-1)−1, so negation never overflows.
- No backpressure: one sample accepted per cycle, every accepted sample emerges exactly once, in order.
- in_valid=0 cycles create bubbles; out_valid=0 in the matching output cycle.
- out_val and out_ch hold their last value while out_valid=0.

## Timing
- Pipeline stages:
  - S1: quarter-offset add, fold, register k/f/negate/tag.
  - S2: ROM read of L[k] (and L[k+1] when interpolating).
  - S3: interpolate (present only with macro).
  - S4: negate, register outputs.
- Latency in_valid → out_valid: 4 cycles with interpolation, 3 without. Throughput 1 sample/cycle.
- Valid and tag travel in a shift pipeline parallel to the data.
- Reset: out_valid=0, out_val=0, out_ch=0; all pipeline valid bits cleared.
- Reset asserted mid-stream: in-flight samples are discarded, no spurious out_valid. The first sample accepted after release appears after the full latency.
- in_cos is sampled with in_phase in the same cycle only.

## Configuration
- QSINE_INTERP_EN defined: second ROM read port, S3 interpolation stage, latency 4.
- Not defined: y = L[k], f ignored, no S3 and no multiplier, latency 3.
- Port list is identical in both builds.

## Test plan
- Defaults, macro on, in_phase=0x0000 → out_val=101 after 4 cycles; 0x8000 → −101.
- in_phase=0x4000 (mirror → k=255, f=63, flat top) → 32767; 0xC000 → −32767; in_phase=0x0000 with in_cos=1 → 32767.
- Sweep in_phase 0..0xFFFF step 1, valid every cycle → within ±2 LSB of 32767·sin(2π·(p+32)/65536) everywhere; out_valid continuous; quarter-wave symmetry exact (val(p) = −val(p+0x8000)).
- Back-to-back tags 0..7 with in_valid toggling 1,0,1,1,0… → out_ch sequence and bubbles reproduced exactly, delayed by 4 (3 with macro off).
- Assert reset_n=0 for 1 cycle while 3 samples in flight → out_valid stays 0, outputs 0. Next input produces its correct value after the full latency.
- Macro off, in_phase=0x003F → out_val=101 (frac ignored), latency 3.
